bcd_to_bin: RTL and testbench

- Sequential BCD-to-binary converter for the time/date fields. It is the reverse of the display-side binary-to-BCD path.
- Takes BCD values entered by the user or set logic (ss, mm, hh, dd, mo, yyyy) and produces binary counter-load values for the clock core.
- Uses the reverse double-dabble algorithm: shift right, then subtract 3 from each nibble >= 8. One shift per clock, with a start/busy/done handshake.
- All fields convert in parallel; the year sets the length of the conversion.

---
 rtl/bcd_to_bin.sv | 153 +++++++++++++++
 tb/tb_bcd_to_bin.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift per clock).
// Optional macro RANGE_CHECK_EN adds the range_err output and field range checks.
module bcd_to_bin #(
  parameter int unsigned YEAR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        bcd_ss,
  input  logic [7:0]        bcd_mm,
  input  logic [7:0]        bcd_hh,
  input  logic [7:0]        bcd_dd,
  input  logic [7:0]        bcd_mo,
  input  logic [15:0]       bcd_yyyy,
  output logic              busy,
  output logic              done,
  output logic [5:0]        sec_bin,
  output logic [5:0]        min_bin,
  output logic [4:0]        hour_bin,
  output logic [4:0]        day_bin,
  output logic [3:0]        month_bin,
  output logic [YEAR_W-1:0] year_bin,
  output logic              bcd_err
`ifdef RANGE_CHECK_EN
  ,
  output logic              range_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_perr;
  logic [7:0]  r_ss_bcd, r_mm_bcd, r_hh_bcd, r_dd_bcd, r_mo_bcd;
  logic [7:0]  r_ss_acc, r_mm_acc, r_hh_acc, r_dd_acc, r_mo_acc;
  logic [15:0] r_y_bcd, r_y_acc;

  logic [15:0] w_ybcd_nx, w_ybin_nx;
  logic [31:0] w_year_ext;
  logic        w_in_bad;
  logic        w_range_bad;
  logic        w_unused_bits;

  function automatic logic [3:0] nib_adj(input logic [3:0] n);
    return (n >= 4'd8) ? n - 4'd3 : n;
  endfunction

  function automatic logic bad2(input logic [7:0] b);
    return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  // One step: shift {bcd, acc} right by one, then subtract 3 from each nibble >= 8.
  function automatic logic [7:0] step2(input logic [7:0] b);
    return {nib_adj({1'b0, b[7:5]}), nib_adj(b[4:1])};
  endfunction

  assign w_ybcd_nx  = {nib_adj({1'b0, r_y_bcd[15:13]}), nib_adj(r_y_bcd[12:9]),
                       nib_adj(r_y_bcd[8:5]), nib_adj(r_y_bcd[4:1])};
  assign w_ybin_nx  = {r_y_bcd[0], r_y_acc[15:1]};
  assign w_year_ext = {16'd0, w_ybin_nx};

  assign w_in_bad = bad2(bcd_ss) || bad2(bcd_mm) || bad2(bcd_hh) || bad2(bcd_dd) ||
                    bad2(bcd_mo) || bad2(bcd_yyyy[15:8]) || bad2(bcd_yyyy[7:0]);

`ifdef RANGE_CHECK_EN
  localparam logic [31:0] YEAR_MAX = 32'((64'd1 << YEAR_W) - 64'd1);
  assign w_range_bad = (r_ss_acc > 8'd59) || (r_mm_acc > 8'd59) || (r_hh_acc > 8'd23) ||
                       (r_dd_acc == 8'd0) || (r_dd_acc > 8'd31) ||
                       (r_mo_acc == 8'd0) || (r_mo_acc > 8'd12) ||
                       (w_year_ext > YEAR_MAX);
`else
  assign w_range_bad = 1'b0;
`endif

  // Result bits above each port width are dropped by truncation.
  assign w_unused_bits = ^{r_ss_acc[7:6], r_mm_acc[7:6], r_hh_acc[7:5], r_dd_acc[7:5],
                           r_mo_acc[7:4], w_year_ext};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_perr    <= 1'b0;
      r_ss_bcd  <= '0; r_mm_bcd <= '0; r_hh_bcd <= '0; r_dd_bcd <= '0; r_mo_bcd <= '0;
      r_ss_acc  <= '0; r_mm_acc <= '0; r_hh_acc <= '0; r_dd_acc <= '0; r_mo_acc <= '0;
      r_y_bcd   <= '0;
      r_y_acc   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_err   <= 1'b0;
      sec_bin   <= '0;
      min_bin   <= '0;
      hour_bin  <= '0;
      day_bin   <= '0;
      month_bin <= '0;
      year_bin  <= '0;
`ifdef RANGE_CHECK_EN
      range_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_ss_bcd <= bcd_ss; r_mm_bcd <= bcd_mm; r_hh_bcd <= bcd_hh;
            r_dd_bcd <= bcd_dd; r_mo_bcd <= bcd_mo; r_y_bcd  <= bcd_yyyy;
            r_ss_acc <= '0; r_mm_acc <= '0; r_hh_acc <= '0; r_dd_acc <= '0; r_mo_acc <= '0;
            r_y_acc  <= '0;
            r_perr   <= w_in_bad;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= S_SHIFT;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (r_cnt < 4'd8) begin
            r_ss_bcd <= step2(r_ss_bcd); r_ss_acc <= {r_ss_bcd[0], r_ss_acc[7:1]};
            r_mm_bcd <= step2(r_mm_bcd); r_mm_acc <= {r_mm_bcd[0], r_mm_acc[7:1]};
            r_hh_bcd <= step2(r_hh_bcd); r_hh_acc <= {r_hh_bcd[0], r_hh_acc[7:1]};
            r_dd_bcd <= step2(r_dd_bcd); r_dd_acc <= {r_dd_bcd[0], r_dd_acc[7:1]};
            r_mo_bcd <= step2(r_mo_bcd); r_mo_acc <= {r_mo_bcd[0], r_mo_acc[7:1]};
          end
          r_y_bcd <= w_ybcd_nx;
          r_y_acc <= w_ybin_nx;
          r_cnt   <= r_cnt + 4'd1;
          // Last step: the year result is taken from the step logic, not the register.
          if (r_cnt == 4'd15) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            bcd_err <= r_perr;
`ifdef RANGE_CHECK_EN
            range_err <= !r_perr && w_range_bad;
`endif
            if (!r_perr && !w_range_bad) begin
              sec_bin   <= r_ss_acc[5:0];
              min_bin   <= r_mm_acc[5:0];
              hour_bin  <= r_hh_acc[4:0];
              day_bin   <= r_dd_acc[4:0];
              month_bin <= r_mo_acc[3:0];
              year_bin  <= w_year_ext[YEAR_W-1:0];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin (hand-computed expected values).
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [7:0]  bcd_ss, bcd_mm, bcd_hh, bcd_dd, bcd_mo;
  logic [15:0] bcd_yyyy;
  logic        busy, done, bcd_err;
  logic [5:0]  sec_bin, min_bin;
  logic [4:0]  hour_bin, day_bin;
  logic [3:0]  month_bin;
  logic [11:0] year_bin;
`ifdef RANGE_CHECK_EN
  logic        range_err;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int lat, bc, extra;

  bcd_to_bin #(.YEAR_W(12)) dut (
    .clk(clk), .rst(rst), .start(start),
    .bcd_ss(bcd_ss), .bcd_mm(bcd_mm), .bcd_hh(bcd_hh), .bcd_dd(bcd_dd),
    .bcd_mo(bcd_mo), .bcd_yyyy(bcd_yyyy),
    .busy(busy), .done(done),
    .sec_bin(sec_bin), .min_bin(min_bin), .hour_bin(hour_bin), .day_bin(day_bin),
    .month_bin(month_bin), .year_bin(year_bin), .bcd_err(bcd_err)
`ifdef RANGE_CHECK_EN
    , .range_err(range_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int s, input int m, input int h,
                            input int d, input int mo, input int y);
    check({tag, ".sec"},   32'(sec_bin),   32'(s));
    check({tag, ".min"},   32'(min_bin),   32'(m));
    check({tag, ".hour"},  32'(hour_bin),  32'(h));
    check({tag, ".day"},   32'(day_bin),   32'(d));
    check({tag, ".month"}, 32'(month_bin), 32'(mo));
    check({tag, ".year"},  32'(year_bin),  32'(y));
  endtask

  task automatic set_in(input logic [7:0] ss, input logic [7:0] mm, input logic [7:0] hh,
                        input logic [7:0] dd, input logic [7:0] mo, input logic [15:0] yy);
    bcd_ss = ss; bcd_mm = mm; bcd_hh = hh; bcd_dd = dd; bcd_mo = mo; bcd_yyyy = yy;
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sampled after the capture edge; lat counts edges since capture, bounded at 40.
  task automatic wait_done(input int lat0, output int l, output int b);
    l = lat0;
    b = 0;
    while (l < 40) begin
      if (busy) b++;
      if (done) break;
      tick();
      l++;
    end
  endtask

  task automatic check_flags(input string tag, input int e_bcd, input int e_rng);
    check({tag, ".bcd_err"}, 32'(bcd_err), 32'(e_bcd));
`ifdef RANGE_CHECK_EN
    check({tag, ".range_err"}, 32'(range_err), 32'(e_rng));
`else
    if (e_rng != 0) check({tag, ".range_expect"}, 32'(e_rng), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0;
    set_in(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);
    tick(); tick();
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check_flags("rst", 0, 0);
    check_outs("rst", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();

    // All-zero request
    launch();
    wait_done(0, lat, bc);
    check("zero.latency", 32'(lat), 32'd16);
    check("zero.busy_cycles", 32'(bc), 32'd16);
    check_outs("zero", 0, 0, 0, 0, 0, 0);
`ifdef RANGE_CHECK_EN
    check_flags("zero", 0, 1);
`else
    check_flags("zero", 0, 0);
`endif
    tick();
    check("zero.done_width", 32'(done), 32'd0);
    check("zero.busy_after", 32'(busy), 32'd0);

    // Maximal valid time fields
    set_in(8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 16'h2024);
    launch();
    wait_done(0, lat, bc);
    check("max.latency", 32'(lat), 32'd16);
    check("max.busy_cycles", 32'(bc), 32'd16);
    check_outs("max", 59, 59, 23, 31, 12, 2024);
    check_flags("max", 0, 0);
    tick();
    check("max.done_width", 32'(done), 32'd0);
    check_outs("max.hold", 59, 59, 23, 31, 12, 2024);

    // Year exceeding 12 bits
    set_in(8'h07, 8'h30, 8'h09, 8'h15, 8'h06, 16'h9999);
    launch();
    wait_done(0, lat, bc);
    check("y9999.latency", 32'(lat), 32'd16);
`ifdef RANGE_CHECK_EN
    check_flags("y9999", 0, 1);
    check_outs("y9999", 59, 59, 23, 31, 12, 2024);
`else
    check_flags("y9999", 0, 0);
    check_outs("y9999", 7, 30, 9, 15, 6, 1807);
`endif
    tick();

    // Invalid digit in seconds
    set_in(8'h5A, 8'h10, 8'h11, 8'h12, 8'h03, 16'h2001);
    launch();
    wait_done(0, lat, bc);
    check("badss.latency", 32'(lat), 32'd16);
    check_flags("badss", 1, 0);
`ifdef RANGE_CHECK_EN
    check_outs("badss", 59, 59, 23, 31, 12, 2024);
`else
    check_outs("badss", 7, 30, 9, 15, 6, 1807);
`endif
    tick();

    // Month 13: valid BCD, out of calendar range
    set_in(8'h01, 8'h02, 8'h03, 8'h04, 8'h13, 16'h2002);
    launch();
    wait_done(0, lat, bc);
`ifdef RANGE_CHECK_EN
    check_flags("mo13", 0, 1);
    check_outs("mo13", 59, 59, 23, 31, 12, 2024);
`else
    check_flags("mo13", 0, 0);
    check_outs("mo13", 1, 2, 3, 4, 13, 2002);
`endif
    tick();

    // Good request clears previous error
    set_in(8'h45, 8'h08, 8'h17, 8'h01, 8'h01, 16'h1999);
    launch();
    wait_done(0, lat, bc);
    check_flags("good", 0, 0);
    check_outs("good", 45, 8, 17, 1, 1, 1999);
    tick();

    // Restart during SHIFT ignored; input changes during SHIFT ignored
    set_in(8'h33, 8'h44, 8'h12, 8'h28, 8'h02, 16'h2000);
    launch();
    tick(); tick(); tick();
    set_in(8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);
    launch();
    wait_done(4, lat, bc);
    check("restart.latency", 32'(lat), 32'd16);
    check_outs("restart", 33, 44, 12, 28, 2, 2000);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) extra++;
    end
    check("restart.extra_done", 32'(extra), 32'd0);

    // Back-to-back: start in the done cycle
    set_in(8'h10, 8'h20, 8'h21, 8'h30, 8'h07, 16'h2100);
    launch();
    wait_done(0, lat, bc);
    check("b2b1.done", 32'(done), 32'd1);
    check_outs("b2b1", 10, 20, 21, 30, 7, 2100);
    set_in(8'h00, 8'h01, 8'h00, 8'h09, 8'h11, 16'h0001);
    launch();
    check("b2b2.busy", 32'(busy), 32'd1);
    check("b2b2.done_low", 32'(done), 32'd0);
    wait_done(0, lat, bc);
    check("b2b2.latency", 32'(lat), 32'd16);
    check("b2b2.busy_cycles", 32'(bc), 32'd16);
    check_outs("b2b2", 0, 1, 0, 9, 11, 1);
    check_flags("b2b2", 0, 0);
    tick();

    // Reset in the middle of a conversion
    set_in(8'h50, 8'h50, 8'h20, 8'h20, 8'h10, 16'h1000);
    launch();
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check_flags("midrst", 0, 0);
    check_outs("midrst", 0, 0, 0, 0, 0, 0);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) extra++;
    end
    check("midrst.no_done", 32'(extra), 32'd0);

    set_in(8'h12, 8'h34, 8'h05, 8'h20, 8'h10, 16'h1987);
    launch();
    wait_done(0, lat, bc);
    check("post.latency", 32'(lat), 32'd16);
    check_outs("post", 12, 34, 5, 20, 10, 1987);
    check_flags("post", 0, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
